// File: rtl/slot_pkg.sv
// Shared types and constants for the slot machine judge.
// Symbols run 0..4; symbol 4 is the jackpot face.
package slot_pkg;

  localparam int SYM_W = 3;
  localparam logic [SYM_W-1:0] SYM_MAX = 3'b100;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SPIN3,
    ST_CAP0,
    ST_SPIN2,
    ST_CAP1,
    ST_SPIN1,
    ST_CAP2,
    ST_JUDGE,
    ST_PAY
  } state_t;

  localparam logic [1:0] WIN_NONE   = 2'b00;
  localparam logic [1:0] WIN_PAIR   = 2'b01;
  localparam logic [1:0] WIN_TRIPLE = 2'b10;
  localparam logic [1:0] WIN_JACK   = 2'b11;

endpackage

// File: rtl/btn_edge.sv
// Active-low button press detector.
// One register holds the previous level; press = was released, now low.
module btn_edge (
  input  logic clk,
  input  logic clrb,
  input  logic btn_n,
  output logic press
);

  logic prev;

  always_ff @(posedge clk or negedge clrb) begin
    if (!clrb) prev <= 1'b1;
    else       prev <= btn_n;
  end

  assign press = prev & ~btn_n;

endmodule

// File: rtl/slot_judge.sv
// Reel run control, symbol capture, grading and credit keeping
// for a three-reel slot machine.
module slot_judge
  import slot_pkg::*;
#(
  parameter int CREDIT_W    = 8,
  parameter int INIT_CREDIT = 3,
  parameter int BET         = 1,
  parameter int PAY_PAIR    = 1,
  parameter int PAY_TRIPLE  = 5,
  parameter int PAY_JACK    = 20
) (
  input  logic                clk,
  input  logic                clrb,
  input  logic                coin_n,
  input  logic                start_n,
  input  logic                stop_n,
  input  logic [SYM_W-1:0]    reel0,
  input  logic [SYM_W-1:0]    reel1,
  input  logic [SYM_W-1:0]    reel2,
  output logic [2:0]          run_n,
  output logic [SYM_W-1:0]    hold0,
  output logic [SYM_W-1:0]    hold1,
  output logic [SYM_W-1:0]    hold2,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          win,
  output logic                busy
);

  localparam logic [31:0] CMAX =
    32'((64'd1 << CREDIT_W) - 64'd1);
  localparam logic [31:0] BET_W = 32'(BET);
  localparam logic [31:0] P_PAIR = 32'(PAY_PAIR);
  localparam logic [31:0] P_TRI = 32'(PAY_TRIPLE);
  localparam logic [31:0] P_JACK = 32'(PAY_JACK);
  localparam logic [CREDIT_W-1:0] CR_INIT =
    CREDIT_W'(INIT_CREDIT);
  localparam logic [CREDIT_W-1:0] CR_SAT =
    CMAX[CREDIT_W-1:0];

  logic coin_ev;
  logic start_ev;
  logic stop_ev;

  btn_edge u_coin (
    .clk   (clk),
    .clrb  (clrb),
    .btn_n (coin_n),
    .press (coin_ev)
  );

  btn_edge u_start (
    .clk   (clk),
    .clrb  (clrb),
    .btn_n (start_n),
    .press (start_ev)
  );

  btn_edge u_stop (
    .clk   (clk),
    .clrb  (clrb),
    .btn_n (stop_n),
    .press (stop_ev)
  );

  state_t               state;
  state_t               state_d;
  logic [2:0]           run_d;
  logic [SYM_W-1:0]     h0_d;
  logic [SYM_W-1:0]     h1_d;
  logic [SYM_W-1:0]     h2_d;
  logic [1:0]           win_d;
  logic [CREDIT_W-1:0]  credit_d;
  logic                 accept;
  logic [31:0]          pay;
  logic [31:0]          base;
  logic [31:0]          sum;

  // Out-of-range symbols never count toward a match.
  logic m01;
  logic m12;
  logic m02;
  logic [1:0] grade;

  always_comb begin
    m01 = (hold0 == hold1) && (hold0 <= SYM_MAX);
    m12 = (hold1 == hold2) && (hold1 <= SYM_MAX);
    m02 = (hold0 == hold2) && (hold0 <= SYM_MAX);
    if (m01 && m12 && hold0 == SYM_MAX)
      grade = WIN_JACK;
    else if (m01 && m12)
      grade = WIN_TRIPLE;
    else if (m01 || m12 || m02)
      grade = WIN_PAIR;
    else
      grade = WIN_NONE;
  end

  always_comb begin
    state_d = state;
    run_d   = run_n;
    h0_d    = hold0;
    h1_d    = hold1;
    h2_d    = hold2;
    win_d   = win;
    accept  = 1'b0;
    pay     = 32'd0;
    unique case (state)
      ST_IDLE: begin
        if (start_ev && 32'(credit) >= BET_W) begin
          accept  = 1'b1;
          win_d   = WIN_NONE;
          run_d   = 3'b000;
          state_d = ST_SPIN3;
        end
      end
      ST_SPIN3: begin
        if (stop_ev) begin
          run_d[0] = 1'b1;
          state_d  = ST_CAP0;
        end
      end
      ST_CAP0: begin
        h0_d    = reel0;
        state_d = ST_SPIN2;
      end
      ST_SPIN2: begin
        if (stop_ev) begin
          run_d[1] = 1'b1;
          state_d  = ST_CAP1;
        end
      end
      ST_CAP1: begin
        h1_d    = reel1;
        state_d = ST_SPIN1;
      end
      ST_SPIN1: begin
        if (stop_ev) begin
          run_d[2] = 1'b1;
          state_d  = ST_CAP2;
        end
      end
      ST_CAP2: begin
        h2_d    = reel2;
        state_d = ST_JUDGE;
      end
      ST_JUDGE: begin
        win_d   = grade;
        state_d = ST_PAY;
      end
      ST_PAY: begin
        unique case (win)
          WIN_PAIR:   pay = P_PAIR;
          WIN_TRIPLE: pay = P_TRI;
          WIN_JACK:   pay = P_JACK;
          default:    pay = 32'd0;
        endcase
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bet is checked against pre-coin credit; additions saturate.
  always_comb begin
    base = 32'(credit) - (accept ? BET_W : 32'd0);
    sum  = base + 32'(coin_ev) + pay;
    if (sum > CMAX) credit_d = CR_SAT;
    else            credit_d = sum[CREDIT_W-1:0];
  end

  always_ff @(posedge clk or negedge clrb) begin
    if (!clrb) begin
      state  <= ST_IDLE;
      run_n  <= 3'b111;
      hold0  <= SYM_MAX;
      hold1  <= SYM_MAX;
      hold2  <= SYM_MAX;
      credit <= CR_INIT;
      win    <= WIN_NONE;
    end else begin
      state  <= state_d;
      run_n  <= run_d;
      hold0  <= h0_d;
      hold1  <= h1_d;
      hold2  <= h2_d;
      credit <= credit_d;
      win    <= win_d;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_slot_judge.sv
// Directed bench for slot_judge: table of rounds plus
// hand sequences for reset, credit limits and saturation.
module tb_slot_judge;

  logic       clk = 1'b0;
  logic       clrb;
  logic       clrb5;
  logic       coin_n;
  logic       start_n;
  logic       stop_n;
  logic [2:0] reel0;
  logic [2:0] reel1;
  logic [2:0] reel2;

  logic [2:0] run_n;
  logic [2:0] hold0;
  logic [2:0] hold1;
  logic [2:0] hold2;
  logic [7:0] credit;
  logic [1:0] win;
  logic       busy;

  logic [2:0] run_n5;
  logic [2:0] hold0_5;
  logic [2:0] hold1_5;
  logic [2:0] hold2_5;
  logic [4:0] credit5;
  logic [1:0] win5;
  logic       busy5;

  always #5 clk = ~clk;

  slot_judge dut (
    .clk     (clk),
    .clrb    (clrb),
    .coin_n  (coin_n),
    .start_n (start_n),
    .stop_n  (stop_n),
    .reel0   (reel0),
    .reel1   (reel1),
    .reel2   (reel2),
    .run_n   (run_n),
    .hold0   (hold0),
    .hold1   (hold1),
    .hold2   (hold2),
    .credit  (credit),
    .win     (win),
    .busy    (busy)
  );

  slot_judge #(
    .CREDIT_W    (5),
    .INIT_CREDIT (26)
  ) dut5 (
    .clk     (clk),
    .clrb    (clrb5),
    .coin_n  (coin_n),
    .start_n (start_n),
    .stop_n  (stop_n),
    .reel0   (reel0),
    .reel1   (reel1),
    .reel2   (reel2),
    .run_n   (run_n5),
    .hold0   (hold0_5),
    .hold1   (hold1_5),
    .hold2   (hold2_5),
    .credit  (credit5),
    .win     (win5),
    .busy    (busy5)
  );

  logic sel;
  int   m_credit;
  int   m_win;
  int   m_run;
  int   m_busy;
  int   m_h0;
  int   m_h1;
  int   m_h2;

  always_comb begin
    m_credit = sel ? int'(credit5) : int'(credit);
    m_win    = sel ? int'(win5)    : int'(win);
    m_run    = sel ? int'(run_n5)  : int'(run_n);
    m_busy   = sel ? int'(busy5)   : int'(busy);
    m_h0     = sel ? int'(hold0_5) : int'(hold0);
    m_h1     = sel ? int'(hold1_5) : int'(hold1);
    m_h2     = sel ? int'(hold2_5) : int'(hold2);
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_total++;
    if (act != exp)
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    else
      n_pass++;
  endtask

  // m: bit0 coin, bit1 start, bit2 stop
  task automatic press(input logic [2:0] m);
    @(negedge clk);
    coin_n  = ~m[0];
    start_n = ~m[1];
    stop_n  = ~m[2];
    @(negedge clk);
    coin_n  = 1'b1;
    start_n = 1'b1;
    stop_n  = 1'b1;
  endtask

  task automatic round(input logic [2:0] r0,
                       input logic [2:0] r1,
                       input logic [2:0] r2,
                       output int w,
                       output int c_start,
                       output int c_pre,
                       output int c_post);
    press(3'b010);
    c_start = m_credit;
    reel0 = r0;
    press(3'b100);
    reel1 = r1;
    press(3'b100);
    reel2 = r2;
    press(3'b100);
    @(negedge clk);
    @(negedge clk);
    c_pre = m_credit;
    @(negedge clk);
    c_post = m_credit;
    w = m_win;
  endtask

  typedef struct {
    logic [2:0] r0;
    logic [2:0] r1;
    logic [2:0] r2;
    int         w;
    int         delta;
  } vec_t;

  vec_t vt[8];

  int w;
  int cs;
  int cp;
  int cq;
  int cur;

  initial begin
    vt[0] = '{3'd4, 3'd4, 3'd4, 3, 19};
    vt[1] = '{3'd1, 3'd3, 3'd1, 1, 0};
    vt[2] = '{3'd0, 3'd1, 3'd2, 0, -1};
    vt[3] = '{3'd3, 3'd3, 3'd3, 2, 4};
    vt[4] = '{3'd5, 3'd5, 3'd5, 0, -1};
    vt[5] = '{3'd2, 3'd5, 3'd5, 0, -1};
    vt[6] = '{3'd0, 3'd2, 3'd2, 1, 0};
    vt[7] = '{3'd4, 3'd4, 3'd3, 1, 0};

    sel = 1'b0;
    clrb = 1'b0;
    clrb5 = 1'b0;
    coin_n = 1'b1;
    start_n = 1'b1;
    stop_n = 1'b1;
    reel0 = 3'd0;
    reel1 = 3'd0;
    reel2 = 3'd0;
    repeat (2) @(negedge clk);
    clrb = 1'b1;
    @(negedge clk);

    chk("rst_run", m_run, 7);
    chk("rst_hold0", m_h0, 4);
    chk("rst_hold1", m_h1, 4);
    chk("rst_hold2", m_h2, 4);
    chk("rst_credit", m_credit, 3);
    chk("rst_win", m_win, 0);
    chk("rst_busy", m_busy, 0);

    press(3'b010);
    chk("start_credit", m_credit, 2);
    chk("start_run", m_run, 0);
    chk("start_busy", m_busy, 1);
    reel0 = 3'd2;
    press(3'b100);
    chk("stop0_run", m_run, 1);
    @(negedge clk);
    chk("cap_hold0", m_h0, 2);
    reel1 = 3'd2;
    press(3'b100);
    chk("stop1_run", m_run, 3);
    reel2 = 3'd0;
    press(3'b100);
    chk("stop2_run", m_run, 7);
    repeat (3) @(negedge clk);
    chk("seq_win", m_win, 1);
    chk("seq_credit", m_credit, 3);

    cur = m_credit;
    for (int i = 0; i < 8; i++) begin
      round(vt[i].r0, vt[i].r1, vt[i].r2,
            w, cs, cp, cq);
      chk($sformatf("v%0d_bet", i), cs, cur - 1);
      chk($sformatf("v%0d_lat", i), cp, cur - 1);
      chk($sformatf("v%0d_win", i), w, vt[i].w);
      chk($sformatf("v%0d_credit", i), cq,
          cur + vt[i].delta);
      chk($sformatf("v%0d_h0", i), m_h0, int'(vt[i].r0));
      chk($sformatf("v%0d_h1", i), m_h1, int'(vt[i].r1));
      chk($sformatf("v%0d_h2", i), m_h2, int'(vt[i].r2));
      chk($sformatf("v%0d_busy", i), m_busy, 0);
      cur = cur + vt[i].delta;
    end

    press(3'b100);
    chk("idle_stop_run", m_run, 7);
    chk("idle_stop_busy", m_busy, 0);

    // Asynchronous reset while waiting in SPIN2.
    press(3'b010);
    reel0 = 3'd1;
    press(3'b100);
    @(negedge clk);
    chk("spin2_run", m_run, 1);
    #2 clrb = 1'b0;
    #1;
    chk("arst_run", m_run, 7);
    chk("arst_busy", m_busy, 0);
    chk("arst_credit", m_credit, 3);
    chk("arst_hold0", m_h0, 4);
    stop_n = 1'b0;
    @(negedge clk);
    clrb = 1'b1;
    repeat (3) @(negedge clk);
    chk("held_stop_run", m_run, 7);
    chk("held_stop_busy", m_busy, 0);
    stop_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++)
      round(3'd0, 3'd1, 3'd2, w, cs, cp, cq);
    chk("drain_credit", m_credit, 0);
    press(3'b010);
    chk("broke_busy", m_busy, 0);
    chk("broke_run", m_run, 7);
    chk("broke_credit", m_credit, 0);
    press(3'b011);
    chk("coinstart_busy", m_busy, 0);
    chk("coinstart_credit", m_credit, 1);
    press(3'b010);
    chk("accept_busy", m_busy, 1);
    chk("accept_credit", m_credit, 0);
    press(3'b001);
    chk("spin_coin_credit", m_credit, 1);
    reel0 = 3'd0;
    press(3'b100);
    reel1 = 3'd1;
    press(3'b100);
    reel2 = 3'd2;
    press(3'b100);
    repeat (3) @(negedge clk);
    chk("coin_round_credit", m_credit, 1);
    chk("coin_round_busy", m_busy, 0);

    // Narrow-counter instance for saturation.
    clrb = 1'b0;
    @(negedge clk);
    sel = 1'b1;
    clrb5 = 1'b1;
    @(negedge clk);
    chk("w5_rst_credit", m_credit, 26);
    round(3'd4, 3'd4, 3'd4, w, cs, cp, cq);
    chk("w5_bet", cs, 25);
    chk("w5_jack_win", w, 3);
    chk("w5_jack_sat", cq, 31);
    press(3'b010);
    chk("w5_bet2", m_credit, 30);
    reel0 = 3'd1;
    press(3'b100);
    reel1 = 3'd1;
    press(3'b100);
    reel2 = 3'd2;
    press(3'b100);
    @(negedge clk);
    @(negedge clk);
    coin_n = 1'b0;
    @(negedge clk);
    coin_n = 1'b1;
    chk("w5_pay_coin_win", m_win, 1);
    chk("w5_pay_coin_sat", m_credit, 31);
    chk("w5_pay_coin_busy", m_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
